// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between fetch and data ports.
// Optional bus timeout: define MEM_TIMEOUT_EN (uses TIMEOUT_CYCLES).
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_done,
    output logic [31:0] fetch_rdata,
    output logic        fetch_err,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_done,
    output logic [31:0] data_rdata,
    output logic        data_err,
    output logic        mem_ready,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata,
    output logic        owner
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nx;
    logic        last_owner, last_owner_nx;
    logic        owner_nx, ready_nx, instr_nx;
    logic [31:0] addr_nx, wdata_nx;
    logic [3:0]  wstrb_nx;
    logic        fdone_nx, ferr_nx, ddone_nx, derr_nx;
    logic [31:0] frdata_nx, drdata_nx;
    logic        grant_d;
    logic        expired;
    logic        finish;
    logic [31:0] rsp_data;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt, cnt_nx;

    // A response arriving on the last allowed cycle wins over the timeout.
    assign expired = !mem_valid && (cnt == LIMIT);
`else
    assign expired = 1'b0;
`endif

    assign finish   = mem_valid || expired;
    assign rsp_data = mem_valid ? mem_rdata : 32'h0;

    always_comb begin
        state_nx      = state;
        last_owner_nx = last_owner;
        owner_nx      = owner;
        ready_nx      = mem_ready;
        instr_nx      = mem_instr;
        addr_nx       = mem_addr;
        wstrb_nx      = mem_wstrb;
        wdata_nx      = mem_wdata;
        fdone_nx      = 1'b0;
        ferr_nx       = 1'b0;
        frdata_nx     = 32'h0;
        ddone_nx      = 1'b0;
        derr_nx       = 1'b0;
        drdata_nx     = 32'h0;
        grant_d       = data_req && (!fetch_req || !last_owner);
`ifdef MEM_TIMEOUT_EN
        cnt_nx        = cnt;
`endif
        unique case (state)
            IDLE: begin
                if (fetch_req || data_req) begin
                    owner_nx = grant_d;
                    ready_nx = 1'b1;
                    instr_nx = !grant_d;
                    addr_nx  = grant_d ? data_addr : fetch_addr;
                    wstrb_nx = grant_d ? data_wstrb : 4'h0;
                    wdata_nx = grant_d ? data_wdata : 32'h0;
                    state_nx = BUSY;
`ifdef MEM_TIMEOUT_EN
                    cnt_nx   = '0;
`endif
                end
            end
            BUSY: begin
                if (finish) begin
                    ready_nx      = 1'b0;
                    last_owner_nx = owner;
                    state_nx      = DONE;
                    if (owner) begin
                        ddone_nx  = 1'b1;
                        derr_nx   = expired;
                        drdata_nx = rsp_data;
                    end else begin
                        fdone_nx  = 1'b1;
                        ferr_nx   = expired;
                        frdata_nx = rsp_data;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else begin
                    cnt_nx = cnt + 1'b1;
                end
`endif
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_owner  <= 1'b0;
            owner       <= 1'b0;
            mem_ready   <= 1'b0;
            mem_instr   <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wstrb   <= 4'h0;
            mem_wdata   <= 32'h0;
            fetch_done  <= 1'b0;
            fetch_err   <= 1'b0;
            fetch_rdata <= 32'h0;
            data_done   <= 1'b0;
            data_err    <= 1'b0;
            data_rdata  <= 32'h0;
        end else begin
            state       <= state_nx;
            last_owner  <= last_owner_nx;
            owner       <= owner_nx;
            mem_ready   <= ready_nx;
            mem_instr   <= instr_nx;
            mem_addr    <= addr_nx;
            mem_wstrb   <= wstrb_nx;
            mem_wdata   <= wdata_nx;
            fetch_done  <= fdone_nx;
            fetch_err   <= ferr_nx;
            fetch_rdata <= frdata_nx;
            data_done   <= ddone_nx;
            data_err    <= derr_nx;
            data_rdata  <= drdata_nx;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else       cnt <= cnt_nx;
    end
`endif

endmodule
